// File: rtl/multicycle_control_if.sv
// Instruction/data bus handshake between the multicycle controller
// and the memory side: requests out, acknowledges and fetched word in.
interface multicycle_control_if;
  logic [31:0] instr;
  logic        fetch_req;
  logic        fetch_ack;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_write;

  modport master (
    output fetch_req,
    output mem_req,
    output mem_write,
    input  instr,
    input  fetch_ack,
    input  mem_ack
  );

  modport slave (
    input  fetch_req,
    input  mem_req,
    input  mem_write,
    output instr,
    output fetch_ack,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_control.sv
// lx32 multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional bus timeout fault guarded by LX32_CTRL_TIMEOUT_EN.
package lx32_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    K_ALU,
    K_LOAD,
    K_STORE,
    K_BRANCH
  } kind_e;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

module multicycle_control
  import lx32_pkg::*;
#(
  parameter int unsigned RETIRE_W       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.master bus,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                alu_src,
  output logic [1:0]          result_src,
  output logic                branch,
  output alu_op_e             alu_control,
  output logic                illegal_instr,
  output logic                bus_fault,
  output logic [RETIRE_W-1:0] retired
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_e;

  state_e  r_state;
  state_e  w_next;

  logic [31:0]         r_ir;
  alu_op_e             r_alu;
  logic                r_alu_src;
  kind_e               r_kind;
  logic [RETIRE_W-1:0] r_retired;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f75;
  logic       w_unused_ir;

  alu_op_e w_alu;
  logic    w_alu_src;
  kind_e   w_kind;
  logic    w_illegal;

  logic w_fetch_req;
  logic w_mem_req;
  logic w_pc;
  logic w_retire;
  logic w_wait_hit;

  assign w_op        = r_ir[6:0];
  assign w_f3        = r_ir[14:12];
  assign w_f75       = r_ir[30];
  assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

  function automatic alu_op_e alu_of(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    w_alu     = ALU_ADD;
    w_alu_src = 1'b0;
    w_kind    = K_ALU;
    w_illegal = 1'b0;
    unique case (1'b1)
      (w_op == OP_R_TYPE): begin
        w_alu = alu_of(w_f3, w_f75);
      end
      (w_op == OP_IMM): begin
        w_alu_src = 1'b1;
        w_alu     = alu_of(w_f3, w_f75 && (w_f3 == 3'b101));
      end
      (w_op == OP_LOAD): begin
        w_alu_src = 1'b1;
        w_kind    = K_LOAD;
      end
      (w_op == OP_STORE): begin
        w_alu_src = 1'b1;
        w_kind    = K_STORE;
      end
      (w_op == OP_BRANCH): begin
        w_alu  = ALU_SUB;
        w_kind = K_BRANCH;
      end
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef LX32_CTRL_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] r_wait;

  assign w_wait_hit = (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive unacknowledged request cycles within one state.
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) begin
      r_wait <= '0;
    end else if ((w_fetch_req && !bus.fetch_ack) ||
                 (w_mem_req && !bus.mem_ack)) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end
`else
  assign w_wait_hit = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_fetch_req = 1'b0;
    w_mem_req   = 1'b0;
    w_pc        = 1'b0;
    w_retire    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_fetch_req = 1'b1;
        if (bus.fetch_ack) w_next = S_DECODE;
        else if (w_wait_hit) w_next = S_FAULT;
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_pc   = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (r_kind)
          K_BRANCH: begin
            w_pc     = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          K_LOAD,
          K_STORE: w_next = S_MEM;
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack) begin
          if (r_kind == K_STORE) begin
            w_pc     = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_wait_hit) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_pc     = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_alu     <= ALU_ADD;
      r_alu_src <= 1'b0;
      r_kind    <= K_ALU;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.fetch_ack) begin
        r_ir <= bus.instr;
      end
      if (r_state == S_DECODE && !w_illegal) begin
        r_alu     <= w_alu;
        r_alu_src <= w_alu_src;
        r_kind    <= w_kind;
      end
      if (w_retire) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
    end
  end

  // Reset forces every output low combinationally, not one edge later.
  assign bus.fetch_req = !rst && w_fetch_req;
  assign bus.mem_req   = !rst && w_mem_req;
  assign bus.mem_write = !rst && w_mem_req && (r_kind == K_STORE);

  assign ir_write  = !rst && (r_state == S_FETCH) && bus.fetch_ack;
  assign pc_write  = !rst && w_pc;
  assign reg_write = !rst && (r_state == S_WB);
  assign alu_src   = !rst && r_alu_src &&
                     ((r_state == S_EXEC) ||
                      (r_state == S_MEM) ||
                      (r_state == S_WB));
  assign result_src = (!rst && (r_state == S_WB) && (r_kind == K_LOAD))
                      ? 2'b01 : 2'b00;
  assign branch = !rst && (r_state == S_EXEC) && (r_kind == K_BRANCH);
  assign alu_control   = rst ? ALU_ADD : r_alu;
  assign illegal_instr = !rst && (r_state == S_DECODE) && w_illegal;
  assign retired       = rst ? '0 : r_retired;

`ifdef LX32_CTRL_TIMEOUT_EN
  assign bus_fault = !rst && (r_state == S_FAULT);
`else
  assign bus_fault = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction table plus
// hand-built reset, wrap and bus-wait sequences.
module tb_multicycle_control;
  import lx32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  logic       ir_write, pc_write, reg_write, alu_src;
  logic [1:0] result_src;
  logic       branch, illegal_instr, bus_fault;
  alu_op_e    alu_control;
  logic [3:0] retired;

  multicycle_control #(
    .RETIRE_W      (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src      (alu_src),
    .result_src   (result_src),
    .branch       (branch),
    .alu_control  (alu_control),
    .illegal_instr(illegal_instr),
    .bus_fault    (bus_fault),
    .retired      (retired)
  );

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  typedef struct {
    logic [31:0] ins;
    int fw;
    int mwt;
    bit sp;
    int len;
    int freq;
    int mreq;
    int mwr;
    int rw;
    int rw_at;
    int rs;
    int ill;
    int br;
    int src;
    alu_op_e alu;
    int inc;
  } vec_t;

  typedef struct {
    int len;
    int freq;
    int mreq;
    int mwr;
    int rw;
    int rw_at;
    int rs;
    int ill;
    int br;
    int src;
    int pc;
    int irw;
  } res_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input int idx,
                     input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d", nm, idx, got, want);
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1
  // of the next FETCH.
  task automatic run_instr(input logic [31:0] ins, input int fw,
                           input int mw, input bit spur,
                           output res_t r);
    int fc = 0;
    int mc = 0;
    bit prev = 1'b0;
    bit done = 1'b0;
    r = '{default: 0};
    r.rw_at = 99;
    r.len = 999;
    bus.instr = ins;
    for (int c = 0; c < 64; c++) begin
      if (c > 0 && bus.fetch_req && !prev) begin
        r.len = c;
        done = 1'b1;
        break;
      end
      bus.fetch_ack = bus.fetch_req ? (fc == fw) : spur;
      bus.mem_ack   = bus.mem_req ? (mc == mw) : spur;
      @(negedge clk);
      if (bus.fetch_req) begin fc++; r.freq++; end
      if (bus.mem_req) begin mc++; r.mreq++; end
      if (bus.mem_write) r.mwr++;
      if (reg_write) begin
        r.rw++;
        if (r.rw_at == 99) r.rw_at = c;
        r.rs = int'(result_src);
      end
      if (illegal_instr) r.ill++;
      if (branch) r.br++;
      if (pc_write) r.pc++;
      if (ir_write) r.irw++;
      if (alu_src) r.src = 1;
      prev = bus.fetch_req;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL instr_timeout ins=%h", ins);
    end
  endtask

  task automatic do_reset_check(input string nm);
    rst = 1'b1;
    @(negedge clk);
    chk({nm, "_mem_req"}, 0, int'(bus.mem_req), 0);
    chk({nm, "_retired"}, 0, int'(retired), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk({nm, "_restart_mem"}, 0, int'(bus.mem_req), 0);
    chk({nm, "_restart_fetch"}, 0, int'(bus.fetch_req), 1);
    chk({nm, "_fault_clr"}, 0, int'(bus_fault), 0);
    chk({nm, "_ret_clr"}, 0, int'(retired), 0);
    exp_ret = 0;
  endtask

  task automatic reach_mem(input logic [31:0] ins);
    bit found = 1'b0;
    bus.instr = ins;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.mem_req) begin
        found = 1'b1;
        break;
      end
      bus.fetch_ack = bus.fetch_req;
      @(posedge clk);
      #1;
    end
    bus.fetch_ack = 1'b0;
    chk("reach_mem", 0, int'(found), 1);
  endtask

  initial begin
    res_t r;
    tbl[0]  = '{32'h40000033, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 0, ALU_SUB,  1};
    tbl[1]  = '{32'h00500093, 3, 0, 0, 7, 4, 0, 0, 1, 6, 0, 0, 0, 1, ALU_ADD,  1};
    tbl[2]  = '{32'h0000A103, 0, 2, 0, 7, 1, 3, 0, 1, 6, 1, 0, 0, 1, ALU_ADD,  1};
    tbl[3]  = '{32'h0020A023, 0, 0, 0, 4, 1, 1, 1, 0, 99, 0, 0, 0, 1, ALU_ADD, 1};
    tbl[4]  = '{32'h00000063, 0, 0, 0, 3, 1, 0, 0, 0, 99, 0, 0, 1, 0, ALU_SUB, 1};
    tbl[5]  = '{32'h0000007F, 0, 0, 0, 2, 1, 0, 0, 0, 99, 0, 1, 0, 0, ALU_SUB, 0};
    tbl[6]  = '{32'h40005033, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 0, ALU_SRA,  1};
    tbl[7]  = '{32'h40005013, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 1, ALU_SRA,  1};
    tbl[8]  = '{32'h00005013, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 1, ALU_SRL,  1};
    tbl[9]  = '{32'h40000013, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 1, ALU_ADD,  1};
    tbl[10] = '{32'h00003033, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 0, ALU_SLTU, 1};
    tbl[11] = '{32'h00004033, 0, 0, 1, 4, 1, 0, 0, 1, 3, 0, 0, 0, 0, ALU_XOR,  1};
    tbl[12] = '{32'h00001033, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 0, ALU_SLL,  1};
    tbl[13] = '{32'h00006013, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 1, ALU_OR,   1};
    tbl[14] = '{32'h00002013, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 1, ALU_SLT,  1};
    tbl[15] = '{32'h00007033, 0, 0, 0, 4, 1, 0, 0, 1, 3, 0, 0, 0, 0, ALU_AND,  1};
    tbl[16] = '{32'h0000A103, 1, 0, 0, 6, 2, 1, 0, 1, 5, 1, 0, 0, 1, ALU_ADD,  1};
    tbl[17] = '{32'h0020A023, 0, 3, 1, 7, 1, 4, 4, 0, 99, 0, 0, 0, 1, ALU_ADD, 1};
    tbl[18] = '{32'h00000073, 2, 0, 0, 4, 3, 0, 0, 0, 99, 0, 1, 0, 0, ALU_ADD, 0};

    bus.instr = '0;
    bus.fetch_ack = 1'b0;
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 0, int'({bus.fetch_req, bus.mem_req, bus.mem_write,
        ir_write, pc_write, reg_write, alu_src, result_src, branch,
        illegal_instr, bus_fault, retired}), 0);
    chk("rst_alu", 0, int'(alu_control), int'(ALU_ADD));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("first_fetch_req", 0, int'(bus.fetch_req), 1);

    for (int i = 0; i < 19; i++) begin
      run_instr(tbl[i].ins, tbl[i].fw, tbl[i].mwt, tbl[i].sp, r);
      chk("len", i, r.len, tbl[i].len);
      chk("fetch_req_cycles", i, r.freq, tbl[i].freq);
      chk("mem_req_cycles", i, r.mreq, tbl[i].mreq);
      chk("mem_write_cycles", i, r.mwr, tbl[i].mwr);
      chk("reg_write_cnt", i, r.rw, tbl[i].rw);
      chk("reg_write_at", i, r.rw_at, tbl[i].rw_at);
      chk("result_src", i, r.rs, tbl[i].rs);
      chk("illegal", i, r.ill, tbl[i].ill);
      chk("branch", i, r.br, tbl[i].br);
      chk("alu_src", i, r.src, tbl[i].src);
      chk("pc_write_cnt", i, r.pc, 1);
      chk("ir_write_cnt", i, r.irw, 1);
      chk("alu_control", i, int'(alu_control), int'(tbl[i].alu));
      exp_ret = (exp_ret + tbl[i].inc) % 16;
      chk("retired", i, int'(retired), exp_ret);
    end
    bus.fetch_ack = 1'b0;
    bus.mem_ack = 1'b0;

    reach_mem(32'h0000A103);
`ifdef LX32_CTRL_TIMEOUT_EN
    begin
      int k;
      k = 99;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus_fault) begin
          k = c;
          break;
        end
        @(posedge clk);
        #1;
      end
      chk("fault_after_waits", 0, k, 8);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("fault_hold", c, int'({bus_fault, bus.mem_req,
            bus.fetch_req, reg_write, pc_write}), 16);
      end
      @(posedge clk);
      #1;
    end
`else
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
    end
    chk("long_wait_mem_req", 0, int'(bus.mem_req), 1);
    chk("long_wait_no_fault", 0, int'(bus_fault), 0);
`endif
    do_reset_check("rst_mid_wait");

    for (int i = 0; i < 17; i++) begin
      run_instr(32'h00500093, 0, 0, 1'b0, r);
      exp_ret = (exp_ret + 1) % 16;
    end
    chk("wrap_17_addi", 0, int'(retired), exp_ret);
    chk("wrap_17_addi_is_1", 0, int'(retired), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
